// File: rtl/ps2_key_tracker_if.sv
// ps2_key_tracker_if
//   Byte-in / event-out bundle between a PS/2 byte source and the key tracker.
//   byte_valid : one-cycle strobe, byte_data carries a freshly received byte
//   byte_data  : received PS/2 byte
//   evt_valid  : pulse, a decoded key event is on evt_code/evt_break
//   evt_code   : {extended, scan code} of the last event, holds between events
//   evt_break  : 1 = release, 0 = make, holds between events
//   master : byte producer / event consumer
//   slave  : the tracker itself
interface ps2_key_tracker_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       evt_valid;
  logic [8:0] evt_code;
  logic       evt_break;

  modport master (
    output byte_valid, byte_data,
    input  evt_valid, evt_code, evt_break
  );

  modport slave (
    input  byte_valid, byte_data,
    output evt_valid, evt_code, evt_break
  );
endinterface

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Parses the raw PS/2 byte stream (E0 extended / F0 break prefixes) into
//   make/break events and keeps a held-key bitmap for NUM_KEYS configured
//   codes, with one-cycle press / release / typematic-repeat pulses.
// Ports
//   clk         : system clock
//   reset       : synchronous active-high, clears all state and outputs
//   clear       : synchronous flush of key_down and parser, no pulses
//   bus         : byte input and decoded event output (slave modport)
//   key_down    : level, key i held
//   key_press   : pulse, key i went 0->1
//   key_release : pulse, key i went 1->0
//   key_repeat  : pulse, make for key i while already held
//   err         : pulse, protocol error or prefix timeout
module ps2_key_tracker #(
  parameter int                      NUM_KEYS    = 4,
  parameter logic [9*NUM_KEYS-1:0]   KEY_CODES   = {9'h060, 9'h063, 9'h06A, 9'h061},
  parameter int                      TIMEOUT_CYC = 2_500_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  ps2_key_tracker_if.slave    bus,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic                err
);

  generate
    if (NUM_KEYS < 1 || NUM_KEYS > 16) begin : g_bad_num_keys
      $error("ps2_key_tracker: NUM_KEYS must be in 1..16");
    end
  endgenerate

  localparam int             CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Decoded event for this cycle, registered onto the outputs below.
  logic       fire_next;
  logic       fire_brk_next;
  logic [8:0] fire_code_next;
  logic       err_next;

  // Keyboard housekeeping bytes (ACK, BAT, echo, resend, overrun, pause)
  // that carry no key information when seen outside a prefix.
  function automatic logic is_ignored(input logic [7:0] b);
    case (b)
      8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1: is_ignored = 1'b1;
      default:                                        is_ignored = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    fire_next      = 1'b0;
    fire_brk_next  = 1'b0;
    fire_code_next = 9'h000;
    err_next       = 1'b0;

    if (clear) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else if (bus.byte_valid) begin
      // Any accepted byte restarts the prefix timeout, including a byte
      // that lands on the expiry cycle.
      cnt_next = '0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.byte_data == 8'hE0) begin
            state_next = ST_EXT;
          end else if (bus.byte_data == 8'hF0) begin
            state_next = ST_BRK;
          end else if (!is_ignored(bus.byte_data)) begin
            fire_next      = 1'b1;
            fire_code_next = {1'b0, bus.byte_data};
          end
        end
        ST_EXT: begin
          if (bus.byte_data == 8'hF0) begin
            state_next = ST_EXT_BRK;
          end else if (bus.byte_data != 8'hE0) begin
            fire_next      = 1'b1;
            fire_code_next = {1'b1, bus.byte_data};
            state_next     = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          state_next = ST_IDLE;
          if (bus.byte_data == 8'hE0 || bus.byte_data == 8'hF0) begin
            err_next = 1'b1;
          end else begin
            fire_next      = 1'b1;
            fire_brk_next  = 1'b1;
            fire_code_next = {(state_reg == ST_EXT_BRK), bus.byte_data};
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end else if (state_reg != ST_IDLE) begin
      if (cnt_reg == CNT_LAST) begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        err_next   = 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.evt_valid <= 1'b0;
      bus.evt_code  <= 9'h000;
      bus.evt_break <= 1'b0;
      err           <= 1'b0;
    end else begin
      bus.evt_valid <= fire_next;
      err           <= err_next;
      if (fire_next) begin
        bus.evt_code  <= fire_code_next;
        bus.evt_break <= fire_brk_next;
      end
    end
  end

  // One tracker per key; duplicate codes simply make several trackers hit.
  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      logic down_reg, press_reg, release_reg, repeat_reg;
      logic hit;

      assign hit = fire_next && (fire_code_next == KEY_CODES[9*gi +: 9]);

      always_ff @(posedge clk) begin
        if (reset || clear) begin
          down_reg    <= 1'b0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
          repeat_reg  <= 1'b0;
        end else begin
          press_reg   <= hit && !fire_brk_next && !down_reg;
          repeat_reg  <= hit && !fire_brk_next &&  down_reg;
          release_reg <= hit &&  fire_brk_next &&  down_reg;
          if (hit) begin
            down_reg <= !fire_brk_next;
          end
        end
      end

      assign key_down[gi]    = down_reg;
      assign key_press[gi]   = press_reg;
      assign key_release[gi] = release_reg;
      assign key_repeat[gi]  = repeat_reg;
    end
  endgenerate

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Testbench for ps2_key_tracker. Keys: 0=061, 1=06A, 2=063, 3=174 (E0 74).
// Prefix timeout shortened to 8 cycles.
module tb_ps2_key_tracker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic [3:0] key_down, key_press, key_release, key_repeat;
  logic err;

  ps2_key_tracker_if bus ();

  ps2_key_tracker #(
    .NUM_KEYS   (4),
    .KEY_CODES  ({9'h174, 9'h063, 9'h06A, 9'h061}),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .bus        (bus.slave),
    .key_down   (key_down),
    .key_press  (key_press),
    .key_release(key_release),
    .key_repeat (key_repeat),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       clr;
    logic       vld;
    logic [7:0] data;
    logic       ev;
    logic [8:0] code;
    logic       brk;
    logic [3:0] kd;
    logic [3:0] pr;
    logic [3:0] rl;
    logic [3:0] rp;
    logic       er;
  } vec_t;

  vec_t vec_q[$];
  vec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   step_no = 0;

  function automatic vec_t mk(input logic rst, input logic clr, input logic vld,
                              input logic [7:0] data, input logic ev,
                              input logic [8:0] code, input logic brk,
                              input logic [3:0] kd, input logic [3:0] pr,
                              input logic [3:0] rl, input logic [3:0] rp,
                              input logic er);
    vec_t v;
    v.rst = rst; v.clr = clr; v.vld = vld; v.data = data;
    v.ev = ev; v.code = code; v.brk = brk;
    v.kd = kd; v.pr = pr; v.rl = rl; v.rp = rp; v.er = er;
    return v;
  endfunction

  // Byte with no expected event.
  function automatic vec_t nb(input logic [7:0] data, input logic [3:0] kd, input logic er);
    return mk(0, 0, 1, data, 0, 9'h000, 0, kd, 4'h0, 4'h0, 4'h0, er);
  endfunction

  // Idle cycle.
  function automatic vec_t idle(input logic [3:0] kd, input logic er);
    return mk(0, 0, 0, 8'h00, 0, 9'h000, 0, kd, 4'h0, 4'h0, 4'h0, er);
  endfunction

  // Byte producing an event.
  function automatic vec_t eb(input logic [7:0] data, input logic [8:0] code, input logic brk,
                              input logic [3:0] kd, input logic [3:0] pr,
                              input logic [3:0] rl, input logic [3:0] rp);
    return mk(0, 0, 1, data, 1, code, brk, kd, pr, rl, rp, 0);
  endfunction

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, step_no, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    reset          = v.rst;
    clear          = v.clr;
    bus.byte_valid = v.vld;
    bus.byte_data  = v.data;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("evt_valid",   {8'h00, bus.evt_valid}, {8'h00, e.ev});
    if (e.ev || e.rst) begin
      chk("evt_code",  bus.evt_code, e.code);
      chk("evt_break", {8'h00, bus.evt_break}, {8'h00, e.brk});
    end
    chk("key_down",    {5'h00, key_down},    {5'h00, e.kd});
    chk("key_press",   {5'h00, key_press},   {5'h00, e.pr});
    chk("key_release", {5'h00, key_release}, {5'h00, e.rl});
    chk("key_repeat",  {5'h00, key_repeat},  {5'h00, e.rp});
    chk("err",         {8'h00, err},         {8'h00, e.er});
    $display("step %0d rst=%0b clr=%0b vld=%0b byte=%h -> ev=%0b code=%h brk=%0b kd=%b pr=%b rl=%b rp=%b err=%0b",
             step_no, v.rst, v.clr, v.vld, v.data, bus.evt_valid, bus.evt_code,
             bus.evt_break, key_down, key_press, key_release, key_repeat, err);
    step_no++;
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // Reset state
    vec_q.push_back(mk(1, 0, 0, 8'h00, 0, 9'h000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    // Make / typematic repeat / break of key 0
    vec_q.push_back(eb(8'h61, 9'h061, 0, 4'b0001, 4'b0001, 4'h0, 4'h0));
    vec_q.push_back(eb(8'h61, 9'h061, 0, 4'b0001, 4'h0, 4'h0, 4'b0001));
    vec_q.push_back(nb(8'hF0, 4'b0001, 0));
    vec_q.push_back(eb(8'h61, 9'h061, 1, 4'b0000, 4'h0, 4'b0001, 4'h0));
    // Extended key 3
    vec_q.push_back(nb(8'hE0, 4'b0000, 0));
    vec_q.push_back(eb(8'h74, 9'h174, 0, 4'b1000, 4'b1000, 4'h0, 4'h0));
    vec_q.push_back(nb(8'hE0, 4'b1000, 0));
    vec_q.push_back(nb(8'hF0, 4'b1000, 0));
    vec_q.push_back(eb(8'h74, 9'h174, 1, 4'b0000, 4'h0, 4'b1000, 4'h0));
    // Prefix timeout: F0 then 8 idle cycles
    vec_q.push_back(nb(8'hF0, 4'b0000, 0));
    for (int i = 0; i < 7; i++) vec_q.push_back(idle(4'b0000, 0));
    vec_q.push_back(idle(4'b0000, 1));
    vec_q.push_back(idle(4'b0000, 0));
    vec_q.push_back(eb(8'h6A, 9'h06A, 0, 4'b0010, 4'b0010, 4'h0, 4'h0));
    // Protocol error F0,E0; ignored bytes
    vec_q.push_back(nb(8'hF0, 4'b0010, 0));
    vec_q.push_back(nb(8'hE0, 4'b0010, 1));
    vec_q.push_back(nb(8'hAA, 4'b0010, 0));
    vec_q.push_back(nb(8'hFA, 4'b0010, 0));
    vec_q.push_back(nb(8'hEE, 4'b0010, 0));
    vec_q.push_back(nb(8'hFE, 4'b0010, 0));
    vec_q.push_back(nb(8'h00, 4'b0010, 0));
    vec_q.push_back(nb(8'hFF, 4'b0010, 0));
    vec_q.push_back(nb(8'hE1, 4'b0010, 0));
    // Unmatched codes still produce events; break of an unheld key
    vec_q.push_back(nb(8'hE0, 4'b0010, 0));
    vec_q.push_back(eb(8'h63, 9'h163, 0, 4'b0010, 4'h0, 4'h0, 4'h0));
    vec_q.push_back(eb(8'h1C, 9'h01C, 0, 4'b0010, 4'h0, 4'h0, 4'h0));
    vec_q.push_back(nb(8'hF0, 4'b0010, 0));
    vec_q.push_back(eb(8'h63, 9'h063, 1, 4'b0010, 4'h0, 4'h0, 4'h0));
    // EXT_BRK then F0 is an error
    vec_q.push_back(nb(8'hE0, 4'b0010, 0));
    vec_q.push_back(nb(8'hF0, 4'b0010, 0));
    vec_q.push_back(nb(8'hF0, 4'b0010, 1));
    // Clear with two keys held, clear beating a byte, clear mid-prefix
    vec_q.push_back(eb(8'h61, 9'h061, 0, 4'b0011, 4'b0001, 4'h0, 4'h0));
    vec_q.push_back(mk(0, 1, 0, 8'h00, 0, 9'h000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    vec_q.push_back(mk(0, 1, 1, 8'h61, 0, 9'h000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    vec_q.push_back(nb(8'hF0, 4'b0000, 0));
    vec_q.push_back(mk(0, 1, 0, 8'h00, 0, 9'h000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    vec_q.push_back(eb(8'h61, 9'h061, 0, 4'b0001, 4'b0001, 4'h0, 4'h0));

    foreach (vec_q[i]) step(vec_q[i]);

    // Reset in the middle of an E0 prefix with key 0 held
    step(nb(8'hE0, 4'b0001, 0));
    step(mk(1, 0, 0, 8'h00, 0, 9'h000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    step(eb(8'h74, 9'h074, 0, 4'b0000, 4'h0, 4'h0, 4'h0));

    // Byte arriving exactly on the expiry cycle is processed, no err
    step(eb(8'h61, 9'h061, 0, 4'b0001, 4'b0001, 4'h0, 4'h0));
    step(nb(8'hF0, 4'b0001, 0));
    for (int i = 0; i < 7; i++) step(idle(4'b0001, 0));
    step(eb(8'h61, 9'h061, 1, 4'b0000, 4'h0, 4'b0001, 4'h0));
    step(idle(4'b0000, 0));

    // Repeated E0 reloads the timeout
    step(nb(8'hE0, 4'b0000, 0));
    for (int i = 0; i < 7; i++) step(idle(4'b0000, 0));
    step(nb(8'hE0, 4'b0000, 0));
    for (int i = 0; i < 7; i++) step(idle(4'b0000, 0));
    step(eb(8'h75, 9'h175, 0, 4'b0000, 4'h0, 4'h0, 4'h0));
    step(idle(4'b0000, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
